// File: rtl/vector_op_master.sv
// vector_op_master: command/operand marshalling front-end for the vector add/sub engine.
// Packs serial A/B elements into 6-lane vectors, runs the start/done handshake, streams C back out.
`default_nettype none

module vector_op_master #(
  parameter int ELEM_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_len_i,
  input  logic                cmd_op_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [ELEM_W-1:0]   in_data_i,
  output logic                eng_start_o,
  output logic                eng_length_o,
  output logic                eng_operation_o,
  output logic [ELEM_W*6-1:0] eng_a_o,
  output logic [ELEM_W*6-1:0] eng_b_o,
  input  logic                eng_done_i,
  input  logic [ELEM_W*6-1:0] eng_c_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [ELEM_W-1:0]   out_data_o,
  output logic                out_last_o,
  output logic                busy_o,
  output logic                err_o
);

  localparam int P  = ELEM_W * 6;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_A    = 3'd1,
    LOAD_B    = 3'd2,
    WAIT_DONE = 3'd3,
    DRAIN     = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic            len_q, len_d;
  logic            op_q, op_d;
  logic            start_q, start_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [P-1:0]    a_q, a_d;
  logic [P-1:0]    b_q, b_d;
  logic [P-1:0]    c_q, c_d;

  logic            last_lane;
  int              lane_lsb;

  assign last_lane = (idx_q == (len_q ? 3'd5 : 3'd3));
  assign lane_lsb  = int'(idx_q) * ELEM_W;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= 1'b0;
      op_q    <= 1'b0;
      start_q <= 1'b0;
      tmo_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      op_q    <= op_d;
      start_q <= start_d;
      tmo_q   <= tmo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
    end
  end

  // A lingering eng_done from the previous job must clear before a new command is taken.
  assign cmd_ready_o = (state_q == IDLE) && !eng_done_i;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    op_d        = op_q;
    start_d     = start_q;
    tmo_d       = tmo_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    out_data_o  = '0;
    out_last_o  = 1'b0;
    err_o       = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          len_d   = cmd_len_i;
          op_d    = cmd_op_i;
          a_d     = '0;
          b_d     = '0;
          idx_d   = '0;
          state_d = LOAD_A;
        end
      end
      LOAD_A: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          a_d[lane_lsb +: ELEM_W] = in_data_i;
          if (last_lane) begin
            idx_d   = '0;
            state_d = LOAD_B;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      LOAD_B: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          b_d[lane_lsb +: ELEM_W] = in_data_i;
          if (last_lane) begin
            idx_d   = '0;
            start_d = 1'b1;
            tmo_d   = '0;
            state_d = WAIT_DONE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      WAIT_DONE: begin
        // Done takes priority over an expiring timeout in the same cycle.
        if (eng_done_i) begin
          c_d     = eng_c_i;
          start_d = 1'b0;
          idx_d   = '0;
          state_d = DRAIN;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_o   = 1'b1;
          start_d = 1'b0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DRAIN: begin
        out_valid_o = 1'b1;
        out_data_o  = c_q[lane_lsb +: ELEM_W];
        out_last_o  = last_lane;
        if (out_ready_i) begin
          if (last_lane) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign eng_start_o     = start_q;
  assign eng_length_o    = len_q;
  assign eng_operation_o = op_q;
  assign eng_a_o         = a_q;
  assign eng_b_o         = b_q;
  assign busy_o          = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_vector_op_master.sv
// Directed bench for vector_op_master with a behavioural add/sub engine model.
`default_nettype none
`timescale 1ns/1ps

module tb_vector_op_master;

  localparam int EW = 32;
  localparam int P  = EW * 6;
  localparam int TO = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic          cmd_len_i = 1'b0;
  logic          cmd_op_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [EW-1:0] in_data_i = '0;
  logic          eng_start_o;
  logic          eng_length_o;
  logic          eng_operation_o;
  logic [P-1:0]  eng_a_o;
  logic [P-1:0]  eng_b_o;
  logic          eng_done_i;
  logic [P-1:0]  eng_c_i;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [EW-1:0] out_data_o;
  logic          out_last_o;
  logic          busy_o;
  logic          err_o;

  vector_op_master #(.ELEM_W(EW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_len_i(cmd_len_i), .cmd_op_i(cmd_op_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .eng_start_o(eng_start_o), .eng_length_o(eng_length_o),
    .eng_operation_o(eng_operation_o), .eng_a_o(eng_a_o), .eng_b_o(eng_b_o),
    .eng_done_i(eng_done_i), .eng_c_i(eng_c_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_last_o(out_last_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [P-1:0] got, input logic [P-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Engine model: 3-cycle latency, optional never-done and sticky-done behaviour.
  logic never_done = 1'b0;
  int   hold_cycles = 0;
  int   lat_cnt, hold_cnt;

  function automatic logic [P-1:0] engine_calc(input logic op, input logic [P-1:0] a, input logic [P-1:0] b);
    logic [P-1:0] c;
    for (int k = 0; k < 6; k++)
      c[k*EW +: EW] = op ? a[k*EW +: EW] - b[k*EW +: EW] : a[k*EW +: EW] + b[k*EW +: EW];
    return c;
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      eng_done_i <= 1'b0; eng_c_i <= '0; lat_cnt <= 0; hold_cnt <= 0;
    end else if (eng_start_o) begin
      if (!eng_done_i && !never_done) begin
        if (lat_cnt == 2) begin
          eng_done_i <= 1'b1;
          eng_c_i    <= engine_calc(eng_operation_o, eng_a_o, eng_b_o);
        end
        lat_cnt <= lat_cnt + 1;
      end
    end else begin
      lat_cnt <= 0;
      if (eng_done_i) begin
        if (hold_cnt < hold_cycles) hold_cnt <= hold_cnt + 1;
        else begin eng_done_i <= 1'b0; hold_cnt <= 0; end
      end
    end
  end

  logic [EW-1:0] a_v [6];
  logic [EW-1:0] b_v [6];
  logic [EW-1:0] e_v [6];

  function automatic logic [P-1:0] pack(input int n, input logic use_b);
    logic [P-1:0] v = '0;
    for (int k = 0; k < n; k++) v[k*EW +: EW] = use_b ? b_v[k] : a_v[k];
    return v;
  endfunction

  task automatic send_cmd(input logic len, input logic op);
    int t = 0;
    cmd_len_i = len; cmd_op_i = op; cmd_valid_i = 1'b1;
    while (!cmd_ready_o && t < 100) begin @(negedge clk_i); t++; end
    if (!cmd_ready_o) check_eq("cmd_ready_wait", cmd_ready_o, 1);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
  endtask

  task automatic push(input logic [EW-1:0] d, input int maxgap);
    int t = 0;
    int g;
    g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    in_valid_i = 1'b0;
    repeat (g) @(negedge clk_i);
    in_data_i = d; in_valid_i = 1'b1;
    while (!in_ready_o && t < 50) begin @(negedge clk_i); t++; end
    if (!in_ready_o) check_eq("in_ready_wait", in_ready_o, 1);
    @(negedge clk_i);
    in_valid_i = 1'b0;
  endtask

  task automatic load(input int n, input logic op, input int maxgap);
    send_cmd(n == 6, op);
    for (int k = 0; k < n; k++) push(a_v[k], maxgap);
    for (int k = 0; k < n; k++) push(b_v[k], maxgap);
  endtask

  task automatic drain(input int n, input logic stall);
    int k = 0;
    int t = 0;
    logic stalled = 1'b0;
    logic first = 1'b1;
    logic [EW-1:0] pd = '0;
    logic pl = 1'b0;
    while (k < n && t < 400) begin
      out_ready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) begin
        check_eq("stall_data", out_data_o, pd);
        check_eq("stall_last", out_last_o, pl);
      end
      stalled = 1'b0;
      if (out_valid_o) begin
        if (first) begin
          check_eq("start_low_in_drain", eng_start_o, 0);
          first = 1'b0;
        end
        if (out_ready_i) begin
          check_eq($sformatf("out_data[%0d]", k), out_data_o, e_v[k]);
          check_eq($sformatf("out_last[%0d]", k), out_last_o, (k == n - 1));
          k++;
        end else begin
          stalled = 1'b1; pd = out_data_o; pl = out_last_o;
        end
      end
      @(negedge clk_i);
      t++;
    end
    out_ready_i = 1'b0;
    check_eq("drain_count", k, n);
    check_eq("post_drain_valid", out_valid_o, 0);
    check_eq("post_drain_busy", busy_o, 0);
  endtask

  task automatic check_loaded(input int n, input logic op);
    check_eq("eng_start", eng_start_o, 1);
    check_eq("eng_a", eng_a_o, pack(n, 1'b0));
    check_eq("eng_b", eng_b_o, pack(n, 1'b1));
    check_eq("eng_length", eng_length_o, (n == 6));
    check_eq("eng_operation", eng_operation_o, op);
  endtask

  task automatic set_vec(input int k, input int a, input int b, input int e);
    a_v[k] = 32'(a); b_v[k] = 32'(b); e_v[k] = 32'(e);
  endtask

  initial begin
    int c;
    logic seen_ov;

    repeat (3) @(negedge clk_i);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_in_ready", in_ready_o, 0);
    check_eq("rst_start", eng_start_o, 0);
    check_eq("rst_out_valid", out_valid_o, 0);
    check_eq("rst_err", err_o, 0);
    check_eq("rst_eng_a", eng_a_o, 0);
    check_eq("rst_cmd_ready", cmd_ready_o, 1);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // n=6 add
    for (int k = 0; k < 6; k++) set_vec(k, k + 1, 10 * (k + 1), 11 * (k + 1));
    load(6, 1'b0, 0);
    check_loaded(6, 1'b0);
    drain(6, 1'b0);

    // n=4 subtract; lanes 4,5 must be cleared from the previous job
    set_vec(0, 100, 1, 99);
    set_vec(1, 200, 2, 198);
    set_vec(2, 300, 3, 297);
    set_vec(3, -5, 7, -12);
    load(4, 1'b1, 0);
    check_loaded(4, 1'b1);
    drain(4, 1'b0);

    // n=6 add under input gaps and output backpressure
    for (int k = 0; k < 6; k++) set_vec(k, k + 1, 10 * (k + 1), 11 * (k + 1));
    load(6, 1'b0, 2);
    check_loaded(6, 1'b0);
    drain(6, 1'b1);

    // timeout: engine never answers
    never_done = 1'b1;
    for (int k = 0; k < 4; k++) set_vec(k, 1, 1, 2);
    load(4, 1'b0, 0);
    check_eq("to_start_rise", eng_start_o, 1);
    c = 0; seen_ov = 1'b0;
    while (!err_o && c < 40) begin
      if (out_valid_o) seen_ov = 1'b1;
      @(negedge clk_i); c++;
    end
    check_eq("to_err_cycle", c, TO - 1);
    @(negedge clk_i);
    check_eq("to_err_pulse", err_o, 0);
    check_eq("to_busy", busy_o, 0);
    check_eq("to_start_low", eng_start_o, 0);
    check_eq("to_no_output", seen_ov, 0);
    never_done = 1'b0;
    for (int k = 0; k < 4; k++) set_vec(k, k + 1, 4 - k, 5);
    load(4, 1'b0, 0);
    drain(4, 1'b0);

    // sticky done: cmd_ready held low until eng_done falls
    hold_cycles = 8;
    for (int k = 0; k < 4; k++) set_vec(k, k + 1, 10 * (k + 1), 11 * (k + 1));
    load(4, 1'b0, 0);
    drain(4, 1'b0);
    check_eq("sticky_done_seen", eng_done_i, 1);
    c = 0;
    while (eng_done_i && c < 50) begin
      check_eq("sticky_ready_low", cmd_ready_o, 0);
      @(negedge clk_i); c++;
    end
    check_eq("sticky_ready_high", cmd_ready_o, 1);
    hold_cycles = 0;

    // reset in the middle of LOAD_B
    for (int k = 0; k < 6; k++) set_vec(k, 7, 9, 0);
    send_cmd(1'b1, 1'b1);
    for (int k = 0; k < 6; k++) push(a_v[k], 0);
    push(b_v[0], 0);
    push(b_v[1], 0);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check_eq("mid_rst_busy", busy_o, 0);
    check_eq("mid_rst_in_ready", in_ready_o, 0);
    check_eq("mid_rst_start", eng_start_o, 0);
    check_eq("mid_rst_len", eng_length_o, 0);
    check_eq("mid_rst_op", eng_operation_o, 0);
    check_eq("mid_rst_a", eng_a_o, 0);
    check_eq("mid_rst_b", eng_b_o, 0);
    check_eq("mid_rst_out_valid", out_valid_o, 0);
    check_eq("mid_rst_err", err_o, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    for (int k = 0; k < 4; k++) set_vec(k, 1, 1, 2);
    load(4, 1'b0, 0);
    check_loaded(4, 1'b0);
    drain(4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule

`default_nettype wire
